stream_arbiter: RTL and testbench
=================================

# stream_arbiter

- Parametrised N-input arbiter with a one-entry registered output stage.
- Each input port offers a `DataType` beat under valid/ready. Each cycle the block selects one requesting port, by fixed priority or round-robin, and captures that port's beat into an output register. The output register drains through a valid/ready port.
- Sits in the CPU core where several producers share one consumer, e.g. multiple request sources contending for a single memory or bus port.
- Supersedes the combinational priority mux for shared-resource paths that need backpressure and fairness.

## Interface
Parameters:
- `DataType`, default `cpu_core_params::CpuData`: payload type.
- `PORTS`, default 4: number of input ports; must be ≥ 1.
- `MODE`, default `selector_params::HIGH_TO_LOW`: arbitration policy.
  - `HIGH_TO_LOW`: port 0 has highest priority.
  - `LOW_TO_HIGH`: port PORTS-1 has highest priority.
  - `ROUND_ROBIN`: rotating priority; `ROUND_ROBIN` is added to `selector_params`.

Ports (`PW` = max(1, $clog2(PORTS))):
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid[PORTS]`  input  1 each  port i offers a beat.
- `in_ready[PORTS]`  output  1 each  port i's beat is taken this cycle.
- `in_data[PORTS]`  input  DataType  payload of port i.
- `in_lock[PORTS]`  input  1 each  request to keep the grant after this beat; ignored unless `STREAM_ARBITER_LOCK_EN` is defined.
- `out_valid`  output  1  the output register holds a beat.
- `out_ready`  input  1  the consumer accepts the beat this cycle.
- `out_data`  output  DataType  registered payload.
- `out_port`  output  PW  index of the port that supplied `out_data`.

## Operation
Output register states:
- EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `accept = !out_valid || out_ready`. A full register drains and refills in the same cycle.

Grant:
- Grant is one-hot and computed combinationally from `in_valid`, `MODE`, the round-robin pointer `rr_ptr`, and the lock state.
- `in_ready[i] = accept && grant[i] && in_valid[i]`. At most one `in_ready` is high in any cycle.
- `in_ready` may depend combinationally on `in_valid` and `out_ready`.

Transfer on port g (`in_ready[g]` high):
- Next edge: `out_data <= in_data[g]`, `out_port <= g`, `out_valid <= 1`.

Drain without refill:
- Condition: `out_valid && out_ready` and no transfer in the same cycle.
- Result: `out_valid <= 0`. `out_data` and `out_port` hold their values.

Holding:
- While `out_valid && !out_ready`, `out_data` and `out_port` are stable and every `in_ready` is 0.

Round-robin (`MODE` = `ROUND_ROBIN`):
- Search starts at `rr_ptr` and ascends with wrap-around.
- After a transfer from g: `rr_ptr <= (g == PORTS-1) ? 0 : g+1`.
- `rr_ptr` is unchanged when no transfer occurs.
- In fixed-priority modes `rr_ptr` exists but has no effect.

PORTS = 1:
- `grant[0] = 1`. `out_port` is constantly 0.

Reset values:
- `out_valid=0`, `out_data='0`, `out_port=0`, `rr_ptr=0`, lock cleared.
- Reset asserted mid-transfer discards the held beat, and `in_ready` is 0 during reset.
- `reset` overrides any simultaneous transfer.

## Timing
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput: one beat per cycle while `out_ready`=1.
- Producers may not retract `in_valid` or change `in_data` before `in_ready`.
- A producer's beat is not guaranteed to be taken. It stalls as long as a higher-priority port keeps requesting (fixed modes) or a lock is held.

## Configuration
Macro: `STREAM_ARBITER_LOCK_EN`.

Defined:
- Lock state consists of `locked` and `owner` (PW bits).
- A transfer from g with `in_lock[g]`=1 sets `locked<=1` and `owner<=g`.
- While locked, only `owner` is eligible, even when it is idle.
- A transfer from `owner` with `in_lock`=0 clears `locked`.
- `rr_ptr` still advances on every transfer.

Not defined:
- `in_lock` is ignored and no lock state is synthesised.
- Arbitration is purely per beat.

## Test plan
- **Reset:** with `reset`=1 and all `in_valid`=1 → every `in_ready`=0. After release: `out_valid`=0, `out_port`=0, `out_data`=0.
- **HIGH_TO_LOW, PORTS=4:**
  - Stimulus: ports 1 and 3 valid, `out_ready`=1.
  - Required: `in_ready[1]` only. Next cycle `out_port`=1, `out_data`=`in_data[1]`. Port 3 is served the cycle after port 1 drops.
- **ROUND_ROBIN, PORTS=4:**
  - Stimulus: all ports valid continuously, `out_ready`=1.
  - Required: `out_port` sequence 0,1,2,3,0,… with one beat per cycle.
- **Backpressure:**
  - Stimulus: `out_valid`=1, `out_ready`=0 for 3 cycles.
  - Required: all `in_ready`=0 and `out_data` stable. On the cycle `out_ready` rises, a new beat is taken, giving a back-to-back refill.
- **Lock (macro defined, ROUND_ROBIN):**
  - Stimulus: port 2 sends 3 beats with `in_lock`=1,1,0 while ports 0 and 3 are valid.
  - Required: `out_port`=2,2,2, then 3, then 0.
  - With the macro undefined, the same stimulus gives 2,3,0,2,….
- **Mid-operation reset:**
  - Stimulus: assert `reset` while FULL and `out_ready`=0.
  - Required: next cycle `out_valid`=0 and `rr_ptr`=0, so port 0 wins first in ROUND_ROBIN.

Source files
------------

// File: rtl/stream_arbiter.sv
// ----------------------------------------------------------------------------
// stream_arbiter
//
// N-input valid/ready arbiter feeding a one-entry registered output stage.
// Each cycle one requesting input is selected, either by fixed priority or by
// round-robin. Its beat is captured into the output register, which drains
// through a valid/ready port. A full register may drain and refill in the
// same cycle, so throughput is one beat per cycle.
//
// Optional feature macro: STREAM_ARBITER_LOCK_EN
//   Defined   : a port may hold the grant across beats through in_lock.
//   Undefined : in_lock is ignored and arbitration is purely per beat.
//
// Parameters
//   DataType : payload type (packed)
//   PORTS    : number of input ports (>= 1)
//   MODE     : HIGH_TO_LOW (port 0 first), LOW_TO_HIGH (port PORTS-1 first),
//              ROUND_ROBIN (rotating start point rr_ptr)
//
// Ports
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   in_valid[i]       : port i offers a beat
//   in_ready[i]       : port i's beat is taken this cycle
//   in_data[i]        : payload of port i
//   in_lock[i]        : keep the grant after this beat (lock build only)
//   out_valid         : output register holds a beat
//   out_ready         : consumer takes the beat this cycle
//   out_data          : registered payload
//   out_port          : index of the port that supplied out_data
// ----------------------------------------------------------------------------

package selector_params;
    typedef enum logic [1:0] {
        HIGH_TO_LOW,
        LOW_TO_HIGH,
        ROUND_ROBIN
    } selector_e;
endpackage

package cpu_core_params;
    typedef logic [31:0] CpuData;
endpackage

module stream_arbiter #(
    parameter type                       DataType = cpu_core_params::CpuData,
    parameter int                        PORTS    = 4,
    parameter selector_params::selector_e MODE    = selector_params::HIGH_TO_LOW,
    localparam int                       PW       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PORTS-1:0] in_valid,
    output logic [PORTS-1:0] in_ready,
    input  DataType          in_data [PORTS],
    input  logic [PORTS-1:0] in_lock,
    output logic             out_valid,
    input  logic             out_ready,
    output DataType          out_data,
    output logic [PW-1:0]    out_port
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e           state_q, state_d;
    DataType          data_q, data_d;
    logic [PW-1:0]    port_q, port_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             accept;
    logic [PORTS-1:0] request;
    logic [PORTS-1:0] grant;

    // The register can take a new beat when empty or when it drains this cycle.
    assign accept = (state_q == EMPTY) || out_ready;

`ifdef STREAM_ARBITER_LOCK_EN
    logic          locked_q, locked_d;
    logic [PW-1:0] owner_q, owner_d;

    // While locked only the owner is eligible, even if it is not requesting.
    always_comb begin
        request = in_valid;
        if (locked_q) begin
            for (int k = 0; k < PORTS; k++) begin
                if (PW'(k) != owner_q) begin
                    request[k] = 1'b0;
                end
            end
        end
    end

    // Only the owner can transfer while locked, so the lock simply follows
    // the in_lock flag of whichever port transferred last.
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        for (int k = 0; k < PORTS; k++) begin
            if (in_ready[k]) begin
                locked_d = in_lock[k];
                owner_d  = PW'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^in_lock;
    assign request     = in_valid;
`endif

    // Grant: first eligible requester in the search order of the chosen mode.
    generate
        if (PORTS == 1) begin : g_single
            assign grant = 1'b1;
        end else begin : g_multi
            always_comb begin
                int   idx;
                logic found;
                grant = '0;
                found = 1'b0;
                idx   = 0;
                for (int k = 0; k < PORTS; k++) begin
                    case (MODE)
                        selector_params::LOW_TO_HIGH: idx = PORTS - 1 - k;
                        selector_params::ROUND_ROBIN: begin
                            idx = int'(rr_ptr_q) + k;
                            if (idx >= PORTS) begin
                                idx = idx - PORTS;
                            end
                        end
                        default: idx = k;
                    endcase
                    if (!found && request[idx]) begin
                        grant[idx] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Reset masks in_ready so no producer sees a handshake that is discarded.
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_ready
        assign in_ready[gi] = !reset && accept && grant[gi] && in_valid[gi];
    end

    always_comb begin
        logic xfer;
        state_d  = state_q;
        data_d   = data_q;
        port_d   = port_q;
        rr_ptr_d = rr_ptr_q;
        xfer     = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            if (in_ready[k]) begin
                xfer     = 1'b1;
                data_d   = in_data[k];
                port_d   = PW'(k);
                rr_ptr_d = (k == PORTS - 1) ? '0 : PW'(k + 1);
            end
        end
        if (xfer) begin
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            port_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            port_q   <= port_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_port  = port_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_stream_arbiter
//
// Directed bench for stream_arbiter. Four instances: HIGH_TO_LOW, LOW_TO_HIGH
// and ROUND_ROBIN with 4 ports, plus a single-port instance. Stimulus pushes
// the expected {port, data} of each accepted beat into a per-instance queue;
// a monitor pops and compares whenever a beat leaves the output register.
// in_ready and held-output values are compared directly by the stimulus.
// ----------------------------------------------------------------------------
module tb_stream_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dat [4];
    logic [3:0]  lck;
    logic        ordy;

    logic [3:0]  vld [3];
    logic [3:0]  rdy [3];
    logic        ovld [4];
    logic [1:0]  oport [4];
    logic [31:0] odat [4];

    logic        one_vld;
    logic        one_rdy;
    logic [0:0]  one_port;
    logic [31:0] one_dat [1];

    exp_t        exp_q [4][$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_data;
    int          last_port;

    always #5 clock = ~clock;

    assign one_dat[0] = dat[0];
    assign oport[3]   = {1'b0, one_port};

    stream_arbiter #(.PORTS(4), .MODE(selector_params::HIGH_TO_LOW)) u_h2l (
        .clock(clock), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_data(dat), .in_lock(lck), .out_valid(ovld[0]), .out_ready(ordy),
        .out_data(odat[0]), .out_port(oport[0])
    );

    stream_arbiter #(.PORTS(4), .MODE(selector_params::LOW_TO_HIGH)) u_l2h (
        .clock(clock), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_data(dat), .in_lock(lck), .out_valid(ovld[1]), .out_ready(ordy),
        .out_data(odat[1]), .out_port(oport[1])
    );

    stream_arbiter #(.PORTS(4), .MODE(selector_params::ROUND_ROBIN)) u_rr (
        .clock(clock), .reset(reset), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_data(dat), .in_lock(lck), .out_valid(ovld[2]), .out_ready(ordy),
        .out_data(odat[2]), .out_port(oport[2])
    );

    stream_arbiter #(.PORTS(1), .MODE(selector_params::HIGH_TO_LOW)) u_one (
        .clock(clock), .reset(reset), .in_valid(one_vld), .in_ready(one_rdy),
        .in_data(one_dat), .in_lock(lck[0]), .out_valid(ovld[3]), .out_ready(ordy),
        .out_data(odat[3]), .out_port(one_port)
    );

    // Monitor: a beat leaves the register on an edge where out_valid && out_ready.
    always @(negedge clock) begin
        for (int d = 0; d < 4; d++) begin
            if (reset === 1'b0 && ovld[d] === 1'b1 && ordy === 1'b1) begin
                total++;
                if (exp_q[d].size() == 0) begin
                    bad++;
                    $display("FAIL beat dut%0d: got port=%0d data=%08h, required no beat",
                             d, oport[d], odat[d]);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    if (int'(oport[d]) != mon_e.port || odat[d] !== mon_e.data) begin
                        bad++;
                        $display("FAIL beat dut%0d: got port=%0d data=%08h, required port=%0d data=%08h",
                                 d, oport[d], odat[d], mon_e.port, mon_e.data);
                    end else begin
                        $display("beat dut%0d: port=%0d data=%08h ok", d, oport[d], odat[d]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end else begin
            $display("check %s: %0h ok", nm, act);
        end
    endtask

    task automatic push(input int d, input int p);
        exp_t e;
        e.port = (d == 3) ? 0 : p;
        e.data = dat[p];
        exp_q[d].push_back(e);
        last_data = e.data;
        last_port = e.port;
    endtask

    // One accepted beat on instance d: request mask m, port g must win.
    task automatic beat(input int d, input logic [3:0] m, input int g);
        vld[d] = m;
        #1;
        chk($sformatf("rdy_dut%0d_port%0d", d, g), 32'(rdy[d]), 32'(4'b0001 << g));
        push(d, g);
        tick();
        dat[g] = dat[g] + 32'h10;
    endtask

    logic lock_tab [3] = '{1'b1, 1'b1, 1'b0};
`ifdef STREAM_ARBITER_LOCK_EN
    int   lock_seq [5] = '{2, 2, 2, 3, 0};
`else
    int   lock_seq [5] = '{2, 3, 0, 2, 3};
`endif

    initial begin
        int n2;
        reset   = 1'b1;
        ordy    = 1'b1;
        lck     = '0;
        one_vld = 1'b1;
        for (int d = 0; d < 3; d++) vld[d] = 4'hF;
        for (int p = 0; p < 4; p++) dat[p] = 32'hA000_0000 + 32'(p) * 32'h100;

        // Reset: no handshake while reset is high, outputs clear afterwards.
        tick();
        tick();
        for (int d = 0; d < 3; d++) chk($sformatf("reset_rdy_dut%0d", d), 32'(rdy[d]), 32'h0);
        chk("reset_rdy_one", 32'(one_rdy), 32'h0);
        reset   = 1'b0;
        one_vld = 1'b0;
        for (int d = 0; d < 3; d++) vld[d] = 4'h0;
        tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_valid_dut%0d", d), 32'(ovld[d]), 32'h0);
            chk($sformatf("reset_port_dut%0d", d), 32'(oport[d]), 32'h0);
            chk($sformatf("reset_data_dut%0d", d), odat[d], 32'h0);
        end

        // HIGH_TO_LOW: lowest index wins.
        beat(0, 4'b1010, 1);
        beat(0, 4'b1000, 3);
        beat(0, 4'b1100, 2);
        vld[0] = 4'h0;
        tick();

        // LOW_TO_HIGH: highest index wins.
        beat(1, 4'b0101, 2);
        beat(1, 4'b0001, 0);
        beat(1, 4'b1011, 3);
        vld[1] = 4'h0;
        tick();

        // ROUND_ROBIN: all ports valid gives 0,1,2,3,0,1 at one beat per cycle.
        for (int k = 0; k < 6; k++) beat(2, 4'hF, k % 4);

        // Backpressure: held beat (port 1) stays put, no handshakes.
        ordy   = 1'b0;
        vld[2] = 4'hF;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_rdy", 32'(rdy[2]), 32'h0);
            chk("bp_data", odat[2], last_data);
            chk("bp_port", 32'(oport[2]), 32'(last_port));
            tick();
        end
        ordy = 1'b1;
        beat(2, 4'hF, 2);          // back-to-back refill, rr_ptr was 2
        vld[2] = 4'h0;
        tick();

        // Mid-operation reset: fill with a beat that is then discarded.
        ordy   = 1'b0;
        vld[2] = 4'b0010;
        #1;
        chk("mid_fill_rdy", 32'(rdy[2]), 32'h2);
        tick();
        vld[2] = 4'h0;
        chk("mid_full", 32'(ovld[2]), 32'h1);
        reset  = 1'b1;
        vld[2] = 4'hF;
        #1;
        chk("mid_rst_rdy", 32'(rdy[2]), 32'h0);
        tick();
        reset = 1'b0;
        ordy  = 1'b1;
        chk("mid_rst_empty", 32'(ovld[2]), 32'h0);
        beat(2, 4'hF, 0);          // rr_ptr back at 0
        beat(2, 4'b0010, 1);       // leaves rr_ptr at 2
        vld[2] = 4'h0;
        tick();

        // Lock: port 2 sends three beats with in_lock 1,1,0; ports 0 and 3 busy.
        n2 = 0;
        for (int k = 0; k < 5; k++) begin
            lck    = 4'h0;
            lck[2] = (n2 < 3) ? lock_tab[n2] : 1'b0;
            beat(2, {1'b1, (n2 < 3), 1'b0, 1'b1}, lock_seq[k]);
            if (lock_seq[k] == 2) n2++;
        end
        vld[2] = 4'h0;
        lck    = 4'h0;
        tick();

        // Lock held by an idle owner blocks the other ports.
        lck[1] = 1'b1;
        beat(2, 4'b0010, 1);
        lck    = 4'h0;
`ifdef STREAM_ARBITER_LOCK_EN
        vld[2] = 4'b0001;
        #1;
        chk("lock_idle_owner_rdy", 32'(rdy[2]), 32'h0);
        tick();
        beat(2, 4'b0011, 1);
        beat(2, 4'b0001, 0);
`else
        beat(2, 4'b0001, 0);
`endif
        vld[2] = 4'h0;
        tick();

        // Single port: always granted, out_port stays 0.
        one_vld = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("one_rdy", 32'(one_rdy), 32'h1);
            push(3, 0);
            tick();
            dat[0] = dat[0] + 32'h10;
        end
        one_vld = 1'b0;
        tick();
        tick();
        tick();

        for (int d = 0; d < 4; d++) chk($sformatf("sb_empty_dut%0d", d), 32'(exp_q[d].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
